// File: rtl/top_mul_arb_pkg.sv
// Shared constants and helpers for the multiplier arbiter.
package top_mul_arb_pkg;

  localparam int MAX_REQ     = 8;
  localparam int NUM_REQ_DEF = 4;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W = id_width(NUM_REQ_DEF);

  // Reference round-robin pick: first valid at ptr, ptr+1, ... mod n, one-hot.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input int ptr, input int n);
    logic [MAX_REQ-1:0] oh;
    logic               found;
    int                 idx;
    oh    = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = (ptr + k) % n;
        if (!found && valid[idx]) begin
          oh[idx] = 1'b1;
          found   = 1'b1;
        end
      end
    end
    return oh;
  endfunction

  function automatic logic [2:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++)
      if (oh[i]) idx = idx | 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/top_mul_rr_grant.sv
// Round-robin grant: rotate requests so ptr sits at bit 0, take the lowest set
// bit, rotate the one-hot back into requester order.
module top_mul_rr_grant #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic               en,
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] pri;

  // Rotate, isolate lowest set bit, rotate back; gated by slot availability.
  always_comb begin
    rot   = NUM_REQ'({valid, valid} >> ptr);
    pri   = rot & (~rot + 1'b1);
    grant = '0;
    if (en) grant = NUM_REQ'(({pri, pri} << ptr) >> NUM_REQ);
  end

endmodule

// File: rtl/top_mul_arbiter.sv
// One signed multiplier shared round-robin between NUM_REQ requesters, with a
// single registered result stage carrying the issuing requester's index.
module top_mul_arbiter
  import top_mul_arb_pkg::*;
#(
  parameter int  NUM_REQ    = 4,
  parameter int  DIN0_WIDTH = 4,
  parameter int  DIN1_WIDTH = 4,
  parameter int  DOUT_WIDTH = 4,
  localparam int RSP_ID_W   = id_width(NUM_REQ)
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DOUT_WIDTH-1:0]         rsp_dout,
  output logic [RSP_ID_W-1:0]           rsp_id,
  output logic                          busy
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

  logic                         rsp_valid_q, rsp_valid_d;
  logic [DOUT_WIDTH-1:0]        rsp_dout_q, rsp_dout_d;
  logic [RSP_ID_W-1:0]          rsp_id_q, rsp_id_d;
  logic [RSP_ID_W-1:0]          rr_ptr_q, rr_ptr_d;

  logic                         slot_free;
  logic [NUM_REQ-1:0]           grant;
  logic [RSP_ID_W-1:0]          gnt_idx;
  logic signed [DIN0_WIDTH-1:0] op0;
  logic signed [DIN1_WIDTH-1:0] op1;
  logic signed [PW-1:0]         prod;

  // Slot frees when empty or draining this cycle; no grants while in reset.
  assign slot_free = !rsp_valid_q || rsp_ready;

  top_mul_rr_grant #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (RSP_ID_W)
  ) u_grant (
    .en    (slot_free && ap_rst_n),
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  // Operand mux on the granted index and full-width signed product.
  always_comb begin
    gnt_idx = RSP_ID_W'(onehot2idx(MAX_REQ'(grant)));
    op0     = req_din0[gnt_idx*DIN0_WIDTH +: DIN0_WIDTH];
    op1     = req_din1[gnt_idx*DIN1_WIDTH +: DIN1_WIDTH];
    prod    = op0 * op1;
  end

  // Result register load / drain and pointer advance past the winner.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_dout_d  = rsp_dout_q;
    rsp_id_d    = rsp_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (|grant) begin
      rsp_valid_d = 1'b1;
      rsp_dout_d  = DOUT_WIDTH'(prod);
      rsp_id_d    = gnt_idx;
      rr_ptr_d    = (gnt_idx == RSP_ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_dout_q  <= '0;
      rsp_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_dout_q  <= rsp_dout_d;
      rsp_id_q    <= rsp_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dout  = rsp_dout_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = rsp_valid_q || (|req_valid);

endmodule

// File: tb/tb_top_mul_arbiter.sv
// Bench for top_mul_arbiter: directed grant/hold checks plus a result scoreboard.
module tb_top_mul_arbiter;

  localparam int N = 4;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [N*4-1:0] req_din0;
  logic [N*4-1:0] req_din1;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [3:0]   rsp_dout;
  logic [1:0]   rsp_id;
  logic         busy;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] dout;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  top_mul_arbiter #(
    .NUM_REQ(N), .DIN0_WIDTH(4), .DIN1_WIDTH(4), .DOUT_WIDTH(4)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din0  (req_din0),
    .req_din1  (req_din1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dout  (rsp_dout),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    int p;
    p = $signed(a) * $signed(b);
    return p[3:0];
  endfunction

  // Scoreboard: retire the held result first, then queue any new transfer.
  always @(negedge ap_clk) begin
    exp_t e;
    if (!ap_rst_n) begin
      sb_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_id", 32'(rsp_id), 32'(e.id));
          chk("sb_dout", 32'(rsp_dout), 32'(e.dout));
        end
      end
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) begin
          e.id   = 2'(i);
          e.dout = ref_mul(req_din0[i*4 +: 4], req_din1[i*4 +: 4]);
          sb_q.push_back(e);
        end
    end
  end

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b);
    req_din0[i*4 +: 4] = a;
    req_din1[i*4 +: 4] = b;
  endtask

  // Raise valid on requester i and wait (bounded) for its transfer edge.
  task automatic issue(input int i, input logic [3:0] a, input logic [3:0] b);
    logic got;
    got = 1'b0;
    set_ops(i, a, b);
    req_valid[i] = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge ap_clk);
      got = req_ready[i];
      step();
    end
    req_valid[i] = 1'b0;
    if (!got) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ca[4];
    logic [3:0] cb[4];
    logic [3:0] cr[4];
    ca = '{4'h8, 4'h8, 4'hF, 4'h7};
    cb = '{4'h8, 4'h7, 4'hF, 4'hF};
    cr = '{4'h0, 4'h8, 4'h1, 4'h9};

    ap_rst_n  = 1'b0;
    req_valid = '1;
    req_din0  = '0;
    req_din1  = '0;
    rsp_ready = 1'b1;

    // 1: reset with everyone requesting
    step(); step();
    @(negedge ap_clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_dout", 32'(rsp_dout), 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);
    step();
    ap_rst_n  = 1'b1;
    req_valid = '0;
    step();
    @(negedge ap_clk);
    chk("idle_busy", 32'(busy), 32'h0);

    // 2: single request from requester 2, 3*3 wraps to 4'h9
    step();
    set_ops(2, 4'd3, 4'd3);
    req_valid = 4'b0100;
    @(negedge ap_clk);
    chk("t2_ready", 32'(req_ready), 32'h4);
    chk("t2_busy", 32'(busy), 32'h1);
    step();
    req_valid = '0;
    @(negedge ap_clk);
    chk("t2_valid", 32'(rsp_valid), 32'h1);
    chk("t2_dout", 32'(rsp_dout), 32'h9);
    chk("t2_id", 32'(rsp_id), 32'h2);
    step();

    // 3: wrap corners through requester 0
    for (int k = 0; k < 4; k++) begin
      issue(0, ca[k], cb[k]);
      @(negedge ap_clk);
      chk($sformatf("t3_dout%0d", k), 32'(rsp_dout), 32'(cr[k]));
      step();
    end

    // 4: park pointer at 0 via requester 3, then all requesting
    issue(3, 4'd1, 4'd1);
    for (int i = 0; i < N; i++) set_ops(i, 4'(i + 1), 4'd2);
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge ap_clk);
      chk($sformatf("t4_grant%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      if (k > 0) chk($sformatf("t4_id%0d", k), 32'(rsp_id), 32'((k - 1) % 4));
      step();
    end
    req_valid = '0;
    step(); step();

    // 5: backpressure with requester 1 waiting, then drain+refill same cycle
    rsp_ready = 1'b0;
    issue(0, 4'd2, 4'd3);
    set_ops(1, 4'hE, 4'd3);
    req_valid[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge ap_clk);
      chk("t5_ready", 32'(req_ready), 32'h0);
      chk("t5_valid", 32'(rsp_valid), 32'h1);
      chk("t5_dout", 32'(rsp_dout), 32'h6);
      chk("t5_id", 32'(rsp_id), 32'h0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge ap_clk);
    chk("t5_regrant", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    @(negedge ap_clk);
    chk("t5_nobubble", 32'(rsp_valid), 32'h1);
    chk("t5_id1", 32'(rsp_id), 32'h1);
    chk("t5_dout1", 32'(rsp_dout), 32'hA);
    step();

    // 6: reset while holding a result with pointer at 3
    issue(2, 4'd5, 4'd1);
    rsp_ready = 1'b0;
    ap_rst_n  = 1'b0;
    req_valid = '1;
    for (int i = 0; i < N; i++) set_ops(i, 4'd1, 4'(i));
    @(negedge ap_clk);
    chk("t6_rst_ready", 32'(req_ready), 32'h0);
    step();
    ap_rst_n  = 1'b1;
    rsp_ready = 1'b1;
    @(negedge ap_clk);
    chk("t6_valid", 32'(rsp_valid), 32'h0);
    chk("t6_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    step(); step();
    @(negedge ap_clk);
    chk("sb_left", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
